// File: rtl/pls_seg_scheduler.sv
// Segment FIFO and period scheduler for the four-axis pulse generator.
// Issues one queued 4-axis segment per period with a shared fresh bit.
module pls_seg_scheduler #(
  parameter int DEPTH   = 16,
  parameter int PERIOD  = 1600,
  parameter int READY_W = 4
) (
  input  logic                     clk_4M,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [63:0]              wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     abort,
  input  logic                     clr_err,
  output logic [15:0]              XPluse,
  output logic [15:0]              YPluse,
  output logic [15:0]              APluse,
  output logic [15:0]              BPluse,
  output logic                     readyFlag,
  output logic                     wr_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     underrun,
  output logic                     overflow,
  output logic [15:0]              seg_issued
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PERIOD);

  typedef enum logic [1:0] {IDLE, LOAD, STROBE, WAIT} state_t;

  state_t          state;
  state_t          state_n;
  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [PW-1:0]   pcnt;
  logic            fresh;
  logic            stop_req;
  logic            full;
  logic            push;
  logic            pop;
  logic            at_end;
  logic            halt;
  logic            underrun_set;
  logic [63:0]     head;
  logic            fresh_n;

  assign full       = (count == CW'(DEPTH));
  assign push       = wr_en && !full && !abort;
  assign pop        = (state == LOAD) && !abort;
  assign at_end     = (pcnt == PW'(PERIOD - 1));
  assign halt       = stop_req || stop;
  assign head       = mem[rd_ptr];
  assign fresh_n    = ~fresh;
  assign wr_full    = full;
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  always_comb begin
    state_n      = state;
    underrun_set = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && count != '0) state_n = LOAD;
        end
        LOAD: begin
          state_n = STROBE;
        end
        STROBE: begin
          if (pcnt == PW'(READY_W)) state_n = WAIT;
        end
        WAIT: begin
          if (at_end) begin
            if (halt) begin
              state_n = IDLE;
            end else if (count != '0) begin
              state_n = LOAD;
            end else begin
              state_n      = IDLE;
              underrun_set = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_4M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      readyFlag <= 1'b0;
      stop_req  <= 1'b0;
    end else begin
      state     <= state_n;
      readyFlag <= (state_n == STROBE);
      // Restarting at LOAD keeps successive loads exactly PERIOD apart
      if (state_n == IDLE || state_n == LOAD) pcnt <= '0;
      else pcnt <= pcnt + 1'b1;
      if (state_n == IDLE) stop_req <= 1'b0;
      else if (stop && state != IDLE) stop_req <= 1'b1;
    end
  end

  always_ff @(posedge clk_4M) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_4M or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Words settle on entry to LOAD, one clock ahead of the strobe edge
  always_ff @(posedge clk_4M or posedge rst) begin
    if (rst) begin
      XPluse     <= '0;
      YPluse     <= '0;
      APluse     <= '0;
      BPluse     <= '0;
      fresh      <= 1'b0;
      seg_issued <= '0;
    end else if (state_n == LOAD) begin
      XPluse     <= {head[15:11], fresh_n, head[9:0]};
      YPluse     <= {head[31:27], fresh_n, head[25:16]};
      APluse     <= {head[47:43], fresh_n, head[41:32]};
      BPluse     <= {head[63:59], fresh_n, head[57:48]};
      fresh      <= fresh_n;
      seg_issued <= seg_issued + 1'b1;
    end
  end

  always_ff @(posedge clk_4M or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (underrun_set) underrun <= 1'b1;
      else if (clr_err) underrun <= 1'b0;
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pls_seg_scheduler.sv
// Directed and randomized check of pls_seg_scheduler against a
// queue-based model of issued segments and the fresh bit.
module tb_pls_seg_scheduler;
  localparam int DEPTH   = 16;
  localparam int PERIOD  = 1600;
  localparam int READY_W = 4;

  logic        clk_4M = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        abort = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] XPluse, YPluse, APluse, BPluse;
  logic        readyFlag, wr_full, busy, underrun, overflow;
  logic [4:0]  fifo_count;
  logic [15:0] seg_issued;

  int          n_assert = 0;
  int          n_fail = 0;
  int          rise_cnt = 0;
  logic [63:0] q[$];
  logic        fresh_m = 1'b0;
  int          issued_m = 0;

  always #5 clk_4M = ~clk_4M;
  always @(posedge readyFlag) rise_cnt++;

  pls_seg_scheduler #(
    .DEPTH(DEPTH), .PERIOD(PERIOD), .READY_W(READY_W)
  ) dut (
    .clk_4M(clk_4M), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .stop(stop), .abort(abort), .clr_err(clr_err),
    .XPluse(XPluse), .YPluse(YPluse), .APluse(APluse), .BPluse(BPluse),
    .readyFlag(readyFlag), .wr_full(wr_full), .fifo_count(fifo_count),
    .busy(busy), .underrun(underrun), .overflow(overflow),
    .seg_issued(seg_issued)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_4M);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Accepted only when the model queue has room
  task automatic push(input logic [63:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step(1);
    wr_en = 1'b0;
    if (q.size() < DEPTH) q.push_back(d);
  endtask

  function automatic logic [63:0] issue_seg();
    logic [63:0] s;
    s = q.pop_front();
    fresh_m = ~fresh_m;
    issued_m++;
    for (int k = 0; k < 4; k++) s[16*k+10] = fresh_m;
    return s;
  endfunction

  task automatic wait_rise(input string tag, input int exp_n);
    int n;
    int r0;
    n = 0;
    r0 = rise_cnt;
    while (rise_cnt == r0 && n < PERIOD + 10) begin
      step(1);
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  function automatic logic [63:0] words();
    return {BPluse, APluse, YPluse, XPluse};
  endfunction

  initial begin
    logic [63:0] e;
    int n;
    int r0;

    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_words", words(), 64'h0);
    chk("rst_ready", readyFlag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_flags", {underrun, overflow}, 0);
    chk("rst_issued", seg_issued, 0);

    // three segments, run to underrun
    repeat (3) push(64'h0000_0000_0000_0105);
    chk("t1_count", fifo_count, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t1_busy", busy, 1);
    wait_rise("t1_lat", 1);
    e = issue_seg();
    chk("t1_w1", words(), e);
    chk("t1_fresh1", XPluse[10], 1);
    n = 0;
    while (readyFlag === 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk("t1_ready_w", n, READY_W);
    wait_rise("t1_per2", PERIOD - READY_W);
    e = issue_seg();
    chk("t1_w2", words(), e);
    chk("t1_fresh2", XPluse[10], 0);
    wait_rise("t1_per3", PERIOD);
    e = issue_seg();
    chk("t1_w3", words(), e);
    chk("t1_fresh3", XPluse[10], 1);
    chk("t1_issued", seg_issued, issued_m);
    step(PERIOD - 2);
    chk("t1_busy_end", {busy, underrun}, 2'b10);
    step(1);
    chk("t1_underrun", {busy, underrun}, 2'b01);

    // stop mid-period
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t2_clr", underrun, 0);
    repeat (2) push(rnd64());
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_rise("t2_lat", 1);
    e = issue_seg();
    chk("t2_w1", words(), e);
    r0 = rise_cnt;
    step(100);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(PERIOD - 103);
    chk("t2_busy", busy, 1);
    step(1);
    chk("t2_idle", busy, 0);
    chk("t2_rises", rise_cnt, r0);
    chk("t2_count", fifo_count, q.size());
    chk("t2_underrun", underrun, 0);
    chk("t2_issued", seg_issued, issued_m);

    // fill, overflow, then write while full during LOAD
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    q.delete();
    chk("t3_empty", fifo_count, 0);
    repeat (DEPTH) push(rnd64());
    chk("t3_full", {wr_full, overflow}, 2'b10);
    push(rnd64());
    chk("t3_ovf", {wr_full, overflow}, 2'b11);
    chk("t3_count", fifo_count, DEPTH);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t3_clr", overflow, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wr_en = 1'b1;
    wr_data = rnd64();
    step(1);
    wr_en = 1'b0;
    e = issue_seg();
    chk("t3_ld_count", fifo_count, q.size());
    chk("t3_ld_ovf", overflow, 1);
    chk("t3_w1", words(), e);

    // abort during STROBE, with a discarded same-cycle write
    chk("t3_strobe", readyFlag, 1);
    abort = 1'b1;
    wr_en = 1'b1;
    wr_data = rnd64();
    step(1);
    abort = 1'b0;
    wr_en = 1'b0;
    q.delete();
    chk("t3_ab_ready", readyFlag, 0);
    chk("t3_ab_busy", busy, 0);
    chk("t3_ab_count", fifo_count, 0);
    chk("t3_ab_words", words(), e);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;

    // write on the LOAD cycle with four queued
    repeat (4) push(rnd64());
    start = 1'b1;
    step(1);
    start = 1'b0;
    e = rnd64();
    wr_en = 1'b1;
    wr_data = e;
    step(1);
    wr_en = 1'b0;
    q.push_back(e);
    e = issue_seg();
    chk("t4_count", fifo_count, 4);
    chk("t4_ready", readyFlag, 1);
    chk("t4_w1", words(), e);
    wait_rise("t4_per2", PERIOD);
    e = issue_seg();
    chk("t4_w2", words(), e);
    chk("t4_issued", seg_issued, issued_m);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    q.delete();

    // start with an empty FIFO
    r0 = rise_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    chk("t5_busy", busy, 0);
    chk("t5_rises", rise_cnt, r0);
    chk("t5_underrun", underrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
